// File: rtl/pipe_pkg.sv
// pipe_pkg: shared NOP encoding, MIPS opcodes and pipeline state enum for the IR chain, stall unit and bench.
package pipe_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_ADDI   = 6'b001000;
    localparam logic [5:0]  OP_RTYPE  = 6'b000000;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_t;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping stall, flush and retire event counters for the pipeline.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_ev,
    input  logic        flush_ev,
    input  logic        retire_ev,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_retired
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls  <= '0;
            perf_flushes <= '0;
            perf_retired <= '0;
        end else begin
            perf_stalls  <= perf_stalls + 32'(stall_ev);
            perf_flushes <= perf_flushes + 32'(flush_ev);
            perf_retired <= perf_retired + 32'(retire_ev);
        end
    end
endmodule

// File: rtl/pipe_ir_chain.sv
// pipe_ir_chain: IF/ID..MEM/WB instruction registers with stall/flush control FSM.
// Optional perf counters built when PIPE_PERF_EN is defined.
module pipe_ir_chain
    import pipe_pkg::*;
#(
    parameter int MAX_STALL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_instr,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        branch_taken,
    output logic [31:0] decode_ir,
    output logic [31:0] execute_ir,
    output logic [31:0] memory_ir,
    output logic [31:0] wrback_ir,
    output logic        pc_en,
    output logic [1:0]  pipe_state,
    output logic        err_stall_ovr,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_retired
);
    localparam int CW = $clog2(MAX_STALL + 2);
    pipe_state_t   state, state_nxt;
    logic [CW-1:0] stall_cnt, cnt_nxt;
    logic          err_nxt, hold;
    // the pipe is all NOP during FLUSH, so a stall request there is spurious
    assign hold       = stall && !branch_taken && state != FLUSH;
    assign pc_en      = !rst_n || !hold;
    assign pipe_state = state;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        err_nxt   = err_stall_ovr;
        case (state)
            RUN: begin
                state_nxt = branch_taken ? FLUSH : (stall ? STALL : RUN);
                cnt_nxt   = (!branch_taken && stall) ? CW'(1) : '0;
            end
            STALL: begin
                state_nxt = branch_taken ? FLUSH : (stall ? STALL : RUN);
                if (!branch_taken && stall) begin
                    cnt_nxt = (stall_cnt == CW'(MAX_STALL + 1)) ? stall_cnt : stall_cnt + CW'(1);
                    if (stall_cnt == CW'(MAX_STALL))
                        err_nxt = 1'b1;
                end
            end
            FLUSH:   state_nxt = branch_taken ? FLUSH : RUN;
            default: state_nxt = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            stall_cnt     <= '0;
            err_stall_ovr <= 1'b0;
        end else begin
            state         <= state_nxt;
            stall_cnt     <= cnt_nxt;
            err_stall_ovr <= err_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decode_ir  <= NOP_INSTR;
            execute_ir <= NOP_INSTR;
            memory_ir  <= NOP_INSTR;
            wrback_ir  <= NOP_INSTR;
        end else if (branch_taken) begin
            decode_ir  <= NOP_INSTR;
            execute_ir <= NOP_INSTR;
            memory_ir  <= NOP_INSTR;
            wrback_ir  <= memory_ir;
        end else begin
            decode_ir  <= hold ? decode_ir : (fetch_valid ? fetch_instr : NOP_INSTR);
            execute_ir <= hold ? NOP_INSTR : decode_ir;
            memory_ir  <= execute_ir;
            wrback_ir  <= memory_ir;
        end
    end
`ifdef PIPE_PERF_EN
    pipe_perf_cnt u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_ev     (stall && !branch_taken),
        .flush_ev     (branch_taken),
        .retire_ev    (wrback_ir != NOP_INSTR),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes),
        .perf_retired (perf_retired)
    );
`else
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
    assign perf_retired = '0;
`endif
endmodule

// File: tb/tb_pipe_ir_chain.sv
// tb_pipe_ir_chain: directed self-checking bench for the IR chain (works with or without PIPE_PERF_EN).
module tb_pipe_ir_chain;
    import pipe_pkg::*;
`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] I_ADD  = 32'h0085_2020;
    localparam logic [31:0] I_SUB  = 32'h00a6_2822;
    localparam logic [31:0] I_ADDI = 32'h20e7_0005;
    localparam logic [31:0] I_LW   = 32'h8c02_0000;
    localparam logic [31:0] I_ADD2 = 32'h0044_1820;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic        fetch_valid = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] decode_ir, execute_ir, memory_ir, wrback_ir;
    logic        pc_en, err_stall_ovr;
    logic [1:0]  pipe_state;
    logic [31:0] perf_stalls, perf_flushes, perf_retired;
    int          vectors = 0, errs = 0;

    pipe_ir_chain dut (
        .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
        .stall(stall), .branch_taken(branch_taken), .decode_ir(decode_ir),
        .execute_ir(execute_ir), .memory_ir(memory_ir), .wrback_ir(wrback_ir),
        .pc_en(pc_en), .pipe_state(pipe_state), .err_stall_ovr(err_stall_ovr),
        .perf_stalls(perf_stalls), .perf_flushes(perf_flushes), .perf_retired(perf_retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_decode", decode_ir, NOP_INSTR);
        chk("rst_execute", execute_ir, NOP_INSTR);
        chk("rst_memory", memory_ir, NOP_INSTR);
        chk("rst_wrback", wrback_ir, NOP_INSTR);
        chk("rst_state", 32'(pipe_state), 32'(RUN));
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_err", 32'(err_stall_ovr), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        // straight-line stream, then three invalid fetches
        fetch_valid = 1'b1; fetch_instr = I_ADD;
        step();
        chk("t1_decode_add", decode_ir, I_ADD);
        fetch_instr = I_SUB;
        step();
        fetch_instr = I_ADDI;
        step();
        chk("t1_decode_addi", decode_ir, I_ADDI);
        chk("t1_execute_sub", execute_ir, I_SUB);
        chk("t1_memory_add", memory_ir, I_ADD);
        fetch_valid = 1'b0;
        step();
        chk("t1_wrback_add", wrback_ir, I_ADD);
        chk("t1_pc_en", 32'(pc_en), 32'd1);
        step();
        chk("t1_wrback_sub", wrback_ir, I_SUB);
        step();
        chk("t1_wrback_addi", wrback_ir, I_ADDI);
        step();
        chk("t6_wrback_nop", wrback_ir, NOP_INSTR);
        chk("t6_retired", perf_retired, PERF ? 32'd3 : 32'd0);
        step();
        chk("t6_retired_hold", perf_retired, PERF ? 32'd3 : 32'd0);
        // load-use: two stall cycles
        fetch_valid = 1'b1; fetch_instr = I_LW;
        step();
        fetch_instr = I_ADD2;
        step();
        chk("t2_execute_lw", execute_ir, I_LW);
        stall = 1'b1; fetch_instr = I_ADDI;
        #1;
        chk("t2_pc_en_comb", 32'(pc_en), 32'd0);
        step();
        chk("t2_decode_hold1", decode_ir, I_ADD2);
        chk("t2_execute_nop1", execute_ir, NOP_INSTR);
        chk("t2_memory_lw", memory_ir, I_LW);
        chk("t2_state1", 32'(pipe_state), 32'(STALL));
        chk("t2_pc_en1", 32'(pc_en), 32'd0);
        step();
        chk("t2_decode_hold2", decode_ir, I_ADD2);
        chk("t2_execute_nop2", execute_ir, NOP_INSTR);
        chk("t2_wrback_lw", wrback_ir, I_LW);
        chk("t2_state2", 32'(pipe_state), 32'(STALL));
        chk("t2_err", 32'(err_stall_ovr), 32'd0);
        stall = 1'b0; fetch_instr = I_SUB;
        step();
        chk("t2_decode_sub", decode_ir, I_SUB);
        chk("t2_execute_add2", execute_ir, I_ADD2);
        chk("t2_state_run", 32'(pipe_state), 32'(RUN));
        chk("t2_pc_en_run", 32'(pc_en), 32'd1);
        chk("t2_perf_stalls", perf_stalls, PERF ? 32'd2 : 32'd0);
        // stall overrun
        stall = 1'b1;
        step();
        step();
        chk("t3_err_at2", 32'(err_stall_ovr), 32'd0);
        step();
        chk("t3_err_at3", 32'(err_stall_ovr), 32'd1);
        chk("t3_state", 32'(pipe_state), 32'(STALL));
        stall = 1'b0; fetch_valid = 1'b0;
        step();
        chk("t3_state_run", 32'(pipe_state), 32'(RUN));
        chk("t3_err_sticky", 32'(err_stall_ovr), 32'd1);
        chk("t3_perf_stalls", perf_stalls, PERF ? 32'd5 : 32'd0);
        // taken branch with simultaneous stall
        fetch_valid = 1'b1; fetch_instr = I_BEQ;
        step();
        fetch_instr = I_ADD;
        step();
        fetch_instr = I_SUB;
        step();
        chk("t4_memory_beq", memory_ir, I_BEQ);
        chk("t4_execute_add", execute_ir, I_ADD);
        chk("t4_decode_sub", decode_ir, I_SUB);
        branch_taken = 1'b1; stall = 1'b1; fetch_instr = I_ADDI;
        #1;
        chk("t4_pc_en_comb", 32'(pc_en), 32'd1);
        step();
        chk("t4_decode_nop", decode_ir, NOP_INSTR);
        chk("t4_execute_nop", execute_ir, NOP_INSTR);
        chk("t4_memory_nop", memory_ir, NOP_INSTR);
        chk("t4_wrback_beq", wrback_ir, I_BEQ);
        chk("t4_state_flush", 32'(pipe_state), 32'(FLUSH));
        branch_taken = 1'b0; stall = 1'b0; fetch_valid = 1'b0;
        step();
        chk("t4_state_run", 32'(pipe_state), 32'(RUN));
        chk("t4_perf_flushes", perf_flushes, PERF ? 32'd1 : 32'd0);
        chk("t4_perf_stalls", perf_stalls, PERF ? 32'd5 : 32'd0);
        // asynchronous reset in the middle of a stall
        fetch_valid = 1'b1; fetch_instr = I_ADD;
        step();
        stall = 1'b1;
        step();
        chk("t5_state_stall", 32'(pipe_state), 32'(STALL));
        chk("t5_decode_add", decode_ir, I_ADD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_decode", decode_ir, NOP_INSTR);
        chk("t5_execute", execute_ir, NOP_INSTR);
        chk("t5_memory", memory_ir, NOP_INSTR);
        chk("t5_wrback", wrback_ir, NOP_INSTR);
        chk("t5_state", 32'(pipe_state), 32'(RUN));
        chk("t5_pc_en", 32'(pc_en), 32'd1);
        chk("t5_err", 32'(err_stall_ovr), 32'd0);
        chk("t5_perf_stalls", perf_stalls, 32'd0);
        chk("t5_perf_flushes", perf_flushes, 32'd0);
        chk("t5_perf_retired", perf_retired, 32'd0);
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
